// File: rtl/alarm_trigger_ctrl.sv
// alarm_trigger_ctrl: decides when the alarm sounds from stored alarm time vs running time.
//   Inputs : clock, reset (async, active-high), alarm_time_* / current_time_* (BCD hh:mm digits),
//            one_second (1-cycle tick), alarm_button (armed level), stop_alarm, snooze.
//   Outputs: sound_alarm (registered, 1 while ringing), alarm_state (0 IDLE, 1 RINGING, 2 SNOOZE).
//   Build option: define ALARM_SNOOZE_EN to build the SNOOZE state and its counters.
module alarm_trigger_ctrl #(
    parameter int RING_TIMEOUT_S = 60,
    parameter int SNOOZE_MIN     = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] alarm_time_ms_hr,
    input  logic [3:0] alarm_time_ls_hr,
    input  logic [3:0] alarm_time_ms_min,
    input  logic [3:0] alarm_time_ls_min,
    input  logic [3:0] current_time_ms_hr,
    input  logic [3:0] current_time_ls_hr,
    input  logic [3:0] current_time_ms_min,
    input  logic [3:0] current_time_ls_min,
    input  logic       one_second,
    input  logic       alarm_button,
    input  logic       stop_alarm,
    input  logic       snooze,
    output logic       sound_alarm,
    output logic [1:0] alarm_state
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RINGING = 2'd1;
    logic [1:0] state_q, state_d;
    logic [7:0] ring_sec_q, ring_sec_d;
    logic       match, match_q, trigger, quit;
`ifdef ALARM_SNOOZE_EN
    localparam logic [1:0] SNOOZE = 2'd2;
    logic [3:0] snooze_min_cnt_q, snooze_min_cnt_d;
    logic [5:0] snooze_sec_q, snooze_sec_d;
`else
    localparam int unused_snooze_min = SNOOZE_MIN;
    logic unused_snooze;
    assign unused_snooze = snooze;
`endif

    assign match = {alarm_time_ms_hr, alarm_time_ls_hr, alarm_time_ms_min, alarm_time_ls_min} ==
                   {current_time_ms_hr, current_time_ls_hr, current_time_ms_min, current_time_ls_min};
    // Only the first cycle of a match fires; match_q resets high so 00:00 == 00:00 after reset is silent.
    assign trigger     = match & ~match_q;
    assign quit        = stop_alarm | ~alarm_button;
    assign alarm_state = state_q;

    always_comb begin
        state_d    = state_q;
        ring_sec_d = ring_sec_q;
`ifdef ALARM_SNOOZE_EN
        snooze_min_cnt_d = snooze_min_cnt_q;
        snooze_sec_d     = snooze_sec_q;
`endif
        case (state_q)
            IDLE: begin
                if (trigger & alarm_button) begin
                    state_d    = RINGING;
                    ring_sec_d = 8'd0;
                end
            end
            RINGING: begin
                if (quit) state_d = IDLE;
`ifdef ALARM_SNOOZE_EN
                else if (snooze) begin
                    state_d          = SNOOZE;
                    snooze_min_cnt_d = 4'(SNOOZE_MIN);
                    snooze_sec_d     = 6'd0;
                end
`endif
                else if (one_second) begin
                    if (ring_sec_q == 8'(RING_TIMEOUT_S - 1)) state_d = IDLE;
                    else ring_sec_d = ring_sec_q + 8'd1;
                end
            end
`ifdef ALARM_SNOOZE_EN
            SNOOZE: begin
                if (quit) state_d = IDLE;
                else if (one_second) begin
                    if (snooze_sec_q == 6'd59) begin
                        snooze_sec_d     = 6'd0;
                        snooze_min_cnt_d = snooze_min_cnt_q - 4'd1;
                        if (snooze_min_cnt_q == 4'd1) begin
                            state_d    = RINGING;
                            ring_sec_d = 8'd0;
                        end
                    end else begin
                        snooze_sec_d = snooze_sec_q + 6'd1;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sound_alarm <= 1'b0;
            ring_sec_q  <= 8'd0;
            match_q     <= 1'b1;
`ifdef ALARM_SNOOZE_EN
            snooze_min_cnt_q <= 4'd0;
            snooze_sec_q     <= 6'd0;
`endif
        end else begin
            state_q     <= state_d;
            sound_alarm <= state_d == RINGING;
            ring_sec_q  <= ring_sec_d;
            match_q     <= match;
`ifdef ALARM_SNOOZE_EN
            snooze_min_cnt_q <= snooze_min_cnt_d;
            snooze_sec_q     <= snooze_sec_d;
`endif
        end
    end
endmodule

// File: tb/tb_alarm_trigger_ctrl.sv
// tb_alarm_trigger_ctrl: directed self-checking bench for alarm_trigger_ctrl (RING_TIMEOUT_S=3, SNOOZE_MIN=1).
module tb_alarm_trigger_ctrl;
    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] a_mh, a_lh, a_mm, a_lm;
    logic [3:0] c_mh, c_lh, c_mm, c_lm;
    logic       one_second, alarm_button, stop_alarm, snooze;
    logic       sound_alarm;
    logic [1:0] alarm_state;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         seen;

    alarm_trigger_ctrl #(.RING_TIMEOUT_S(3), .SNOOZE_MIN(1)) dut (
        .clock(clock), .reset(reset),
        .alarm_time_ms_hr(a_mh), .alarm_time_ls_hr(a_lh),
        .alarm_time_ms_min(a_mm), .alarm_time_ls_min(a_lm),
        .current_time_ms_hr(c_mh), .current_time_ls_hr(c_lh),
        .current_time_ms_min(c_mm), .current_time_ls_min(c_lm),
        .one_second(one_second), .alarm_button(alarm_button),
        .stop_alarm(stop_alarm), .snooze(snooze),
        .sound_alarm(sound_alarm), .alarm_state(alarm_state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic sec_pulse();
        one_second = 1'b1;
        tick();
        one_second = 1'b0;
    endtask

    task automatic set_cur(input logic [3:0] mh, lh, mm, lm);
        {c_mh, c_lh, c_mm, c_lm} = {mh, lh, mm, lm};
    endtask

    task automatic retrigger();
        set_cur(0, 7, 3, 1);
        tick();
        set_cur(0, 7, 3, 0);
        tick();
    endtask

    initial begin
        reset = 1'b1;
        {a_mh, a_lh, a_mm, a_lm} = 16'h0000;
        set_cur(0, 0, 0, 0);
        {one_second, alarm_button, stop_alarm, snooze} = 4'b0100;
        tick(3);
        check("reset_sound", sound_alarm, 0);
        check("reset_state", alarm_state, 0);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            seen |= int'(sound_alarm) | int'(alarm_state);
        end
        check("zero_match_silent", seen, 0);

        {a_mh, a_lh, a_mm, a_lm} = {4'd0, 4'd7, 4'd3, 4'd0};
        set_cur(0, 7, 2, 9);
        tick(2);
        check("pre_match_state", alarm_state, 0);
        set_cur(0, 7, 3, 0);
        check("before_edge_sound", sound_alarm, 0);
        tick();
        check("ring_sound", sound_alarm, 1);
        check("ring_state", alarm_state, 1);

        tick(2);
        sec_pulse();
        tick();
        sec_pulse();
        tick(3);
        check("after_2_ticks_sound", sound_alarm, 1);
        sec_pulse();
        check("timeout_sound", sound_alarm, 0);
        check("timeout_state", alarm_state, 0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen |= int'(sound_alarm);
        end
        check("no_rering_same_minute", seen, 0);

        retrigger();
        check("rering_state", alarm_state, 1);
        stop_alarm = 1'b1;
        snooze     = 1'b1;
        tick();
        stop_alarm = 1'b0;
        snooze     = 1'b0;
        check("stop_snooze_state", alarm_state, 0);
        check("stop_snooze_sound", sound_alarm, 0);

        retrigger();
        check("rering2_sound", sound_alarm, 1);
        alarm_button = 1'b0;
        tick();
        check("button_off_state", alarm_state, 0);

        set_cur(0, 7, 3, 1);
        tick();
        set_cur(0, 7, 3, 0);
        tick();
        alarm_button = 1'b1;
        tick(2);
        check("arm_during_match_state", alarm_state, 0);
        check("arm_during_match_sound", sound_alarm, 0);

        retrigger();
        check("rering3_state", alarm_state, 1);
        snooze = 1'b1;
        tick();
        snooze = 1'b0;
`ifdef ALARM_SNOOZE_EN
        check("snooze_state", alarm_state, 2);
        check("snooze_sound", sound_alarm, 0);
        for (int i = 0; i < 59; i++) sec_pulse();
        check("snooze_59_state", alarm_state, 2);
        sec_pulse();
        check("snooze_end_state", alarm_state, 1);
        check("snooze_end_sound", sound_alarm, 1);
`else
        check("no_snooze_state", alarm_state, 1);
        check("no_snooze_sound", sound_alarm, 1);
`endif

        #2;
        reset = 1'b1;
        #1;
        check("async_reset_sound", sound_alarm, 0);
        check("async_reset_state", alarm_state, 0);
        check("async_reset_ring_sec", int'(dut.ring_sec_q), 0);
        check("async_reset_match_q", int'(dut.match_q), 1);
        tick();
        reset = 1'b0;
        tick(3);
        check("post_reset_no_fire", alarm_state, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
